// File: rtl/seg_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_capture: decodes a scanned 7-segment bus back into a coherent frame  |
// | of four BCD digits plus decimal points.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       decimal,
  input  logic       S0_enable,
  input  logic       S1_enable,
  input  logic       S2_enable,
  input  logic       S3_enable,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       code_error,
  output logic       enable_error
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);
  localparam logic [7:0] C_ARM    = 8'(STABLE_CYCLES - 2);

  logic [11:0] w_in;
  logic [11:0] r_sample;
  logic [7:0]  r_cnt;
  logic [3:0]  r_mask;
  logic [15:0] r_shadow;
  logic [3:0]  r_shadow_dp;

  logic        w_changed;
  logic        w_accept;
  logic [3:0]  w_dig;
  logic [3:0]  w_sel;
  logic        w_single;
  logic        w_multi;
  logic        w_commit;
  logic [3:0]  w_mask_base;

  assign w_in = {S3_enable, S2_enable, S1_enable, S0_enable, decimal, seg};

  // The change test looks at the sample being registered so the counter restarts
  // on the same edge the new pattern lands; acceptance then falls STABLE_CYCLES-1
  // edges later and still demands a full STABLE_CYCLES-clock hold.
  assign w_changed   = (w_in != r_sample);
  assign w_accept    = !w_changed && (r_cnt == C_ARM);
  assign w_commit    = (r_mask == 4'b1111);
  assign w_mask_base = w_commit ? 4'b0000 : r_mask;

  always_comb begin
    w_dig = 4'hF;
    case (r_sample[6:0])
      7'b1000000: w_dig = 4'd0;
      7'b1111001: w_dig = 4'd1;
      7'b0100100: w_dig = 4'd2;
      7'b0110000: w_dig = 4'd3;
      7'b0011001: w_dig = 4'd4;
      7'b0010010: w_dig = 4'd5;
      7'b0000010: w_dig = 4'd6;
      7'b1111000: w_dig = 4'd7;
      7'b0000000: w_dig = 4'd8;
      7'b0010000: w_dig = 4'd9;
      default:    w_dig = 4'hF;
    endcase
  end

  always_comb begin
    w_sel    = 4'b0000;
    w_single = 1'b0;
    w_multi  = 1'b0;
    case (r_sample[11:8])
      4'b1110: begin w_sel = 4'b0001; w_single = 1'b1; end
      4'b1101: begin w_sel = 4'b0010; w_single = 1'b1; end
      4'b1011: begin w_sel = 4'b0100; w_single = 1'b1; end
      4'b0111: begin w_sel = 4'b1000; w_single = 1'b1; end
      4'b1111: w_multi = 1'b0;
      default: w_multi = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample     <= '1;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      d0           <= '0;
      d1           <= '0;
      d2           <= '0;
      d3           <= '0;
      dp           <= '0;
      frame_valid  <= 1'b0;
      code_error   <= 1'b0;
      enable_error <= 1'b0;
    end else begin
      r_sample <= w_in;
      if (w_changed) begin
        r_cnt <= '0;
      end else if (r_cnt != C_STABLE) begin
        r_cnt <= r_cnt + 8'd1;
      end

      code_error   <= w_accept && w_single && (w_dig == 4'hF);
      enable_error <= w_accept && w_multi;
      frame_valid  <= w_commit;

      if (w_commit) begin
        d0 <= r_shadow[3:0];
        d1 <= r_shadow[7:4];
        d2 <= r_shadow[11:8];
        d3 <= r_shadow[15:12];
        dp <= r_shadow_dp;
      end

      // A capture on the commit edge lands in the freshly cleared mask.
      if (w_accept && w_single) begin
        for (int i = 0; i < 4; i++) begin
          if (w_sel[i]) begin
            r_shadow[i*4 +: 4] <= w_dig;
            r_shadow_dp[i]     <= ~r_sample[7];
          end
        end
        r_mask <= w_mask_base | w_sel;
      end else begin
        r_mask <= w_mask_base;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// Scoreboard bench for seg_capture: a run-length reference model predicts
// frames and error pulses (with their edge numbers); a negedge monitor checks them.
module tb_seg_capture;

  localparam int S = 4;
  localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};
  localparam logic [11:0] BLANK = 12'hFFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = '1;
  logic       decimal = 1'b1;
  logic       S0_enable = 1'b1, S1_enable = 1'b1, S2_enable = 1'b1, S3_enable = 1'b1;
  logic [3:0] d0, d1, d2, d3, dp;
  logic       frame_valid, code_error, enable_error;

  always #5 clk = ~clk;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .decimal(decimal),
    .S0_enable(S0_enable), .S1_enable(S1_enable), .S2_enable(S2_enable),
    .S3_enable(S3_enable), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp),
    .frame_valid(frame_valid), .code_error(code_error), .enable_error(enable_error)
  );

  int   edge_n = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    rst_q  <= reset;
  end

  typedef struct { int at; logic [19:0] val; } frame_t;
  frame_t fq[$];
  int     cq[$];
  int     eq[$];
  logic [19:0] cur_exp = '0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a pattern held S consecutive clocks is accepted exactly once.
  logic [11:0] m_last = BLANK;
  int          m_run = 1;
  logic [3:0]  m_mask = '0;
  logic [3:0]  m_d [4] = '{default: 4'h0};
  logic [3:0]  m_dp = '0;

  task automatic model_accept(input logic [11:0] p, input int at);
    int zeros, idx;
    logic [3:0] val;
    frame_t f;
    zeros = 4 - $countones(p[11:8]);
    if (zeros == 0) return;
    if (zeros >= 2) begin
      eq.push_back(at);
      return;
    end
    idx = 0;
    for (int i = 0; i < 4; i++) if (!p[8+i]) idx = i;
    val = 4'hF;
    for (int k = 0; k < 10; k++) if (CODES[k] == p[6:0]) val = 4'(k);
    if (val == 4'hF) cq.push_back(at);
    m_d[idx] = val;
    m_dp[idx] = ~p[7];
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin
      f.at = at + 1;
      f.val = {m_d[3], m_d[2], m_d[1], m_d[0], m_dp};
      fq.push_back(f);
      m_mask = '0;
    end
  endtask

  task automatic model_step(input logic [11:0] p, input int at);
    if (p == m_last) m_run++;
    else begin
      m_last = p;
      m_run = 1;
    end
    if (m_run == S) model_accept(p, at);
  endtask

  function automatic logic [11:0] pat(input int idx, input bit dpon, input logic [6:0] s);
    logic [3:0] e;
    e = 4'hF;
    e[idx] = 1'b0;
    return {e, ~dpon, s};
  endfunction

  task automatic drive(input logic [11:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      {S3_enable, S2_enable, S1_enable, S0_enable, decimal, seg} = p;
      model_step(p, edge_n + 1);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1;
      {S3_enable, S2_enable, S1_enable, S0_enable, decimal, seg} = 12'($urandom);
    end
    m_last = BLANK;
    m_run = 1;
    m_mask = '0;
    @(negedge clk);
    reset = 1'b0;
    {S3_enable, S2_enable, S1_enable, S0_enable, decimal, seg} = BLANK;
    model_step(BLANK, edge_n + 1);
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3, input logic [3:0] dps);
    drive(pat(0, dps[0], CODES[v0]), 8);
    drive(pat(1, dps[1], CODES[v1]), 8);
    drive(pat(2, dps[2], CODES[v2]), 8);
    drive(pat(3, dps[3], CODES[v3]), 8);
    drive(BLANK, 4);
  endtask

  // Monitor
  always @(negedge clk) begin
    frame_t f;
    int t;
    if (rst_q) begin
      cur_exp = '0;
      check("reset_outputs", {d3, d2, d1, d0, dp}, 32'h0);
      check("reset_pulses", {frame_valid, code_error, enable_error}, 32'h0);
    end else begin
      if (frame_valid) begin
        if (fq.size() == 0) check("frame_unexpected", frame_valid, 32'h0);
        else begin
          f = fq.pop_front();
          check("frame_edge", edge_n, f.at);
          check("frame_data", {d3, d2, d1, d0, dp}, f.val);
          cur_exp = f.val;
        end
      end else begin
        check("outputs_hold", {d3, d2, d1, d0, dp}, cur_exp);
        if (fq.size() > 0 && fq[0].at <= edge_n) begin
          check("frame_valid_pulse", frame_valid, 32'h1);
          void'(fq.pop_front());
        end
      end
      if (code_error) begin
        if (cq.size() == 0) check("code_error_unexpected", code_error, 32'h0);
        else begin
          t = cq.pop_front();
          check("code_error_edge", edge_n, t);
        end
      end else if (cq.size() > 0 && cq[0] <= edge_n) begin
        check("code_error_pulse", code_error, 32'h1);
        void'(cq.pop_front());
      end
      if (enable_error) begin
        if (eq.size() == 0) check("enable_error_unexpected", enable_error, 32'h0);
        else begin
          t = eq.pop_front();
          check("enable_error_edge", edge_n, t);
        end
      end else if (eq.size() > 0 && eq[0] <= edge_n) begin
        check("enable_error_pulse", enable_error, 32'h1);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    do_reset(3);
    drive(BLANK, 3);

    // Normal frame: 4,3,2,1 with dp on digit 2
    scan(4, 3, 2, 1, 4'b0100);

    // Glitch during digit-1 dwell
    drive(pat(0, 1'b0, CODES[4]), 8);
    drive(pat(1, 1'b0, CODES[3]), 3);
    drive(pat(1, 1'b0, CODES[8]), 2);
    drive(pat(1, 1'b0, CODES[3]), 5);
    drive(pat(2, 1'b1, CODES[2]), 8);
    drive(pat(3, 1'b0, CODES[1]), 8);
    drive(BLANK, 4);

    // Illegal code on digit 2
    drive(pat(0, 1'b0, CODES[7]), 8);
    drive(pat(1, 1'b1, CODES[6]), 8);
    drive(pat(2, 1'b0, 7'b0001110), 8);
    drive(pat(3, 1'b0, CODES[9]), 8);
    drive(BLANK, 4);

    // Bad enables, then a normal scan
    drive({4'b1100, 1'b1, CODES[5]}, 8);
    drive(BLANK, 4);
    scan(0, 5, 8, 9, 4'b1001);

    // Reset mid-frame
    drive(pat(0, 1'b0, CODES[1]), 8);
    drive(pat(1, 1'b0, CODES[2]), 8);
    drive(pat(2, 1'b0, CODES[3]), 8);
    drive(BLANK, 2);
    do_reset(2);
    drive(pat(3, 1'b1, CODES[6]), 8);
    drive(BLANK, 4);
    scan(6, 7, 8, 9, 4'b0010);

    // Randomized dwells
    for (int n = 0; n < 300; n++) begin
      logic [3:0] e;
      logic [6:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        e = 4'hF;
        e[$urandom_range(0, 3)] = 1'b0;
      end else if (r == 6) e = 4'hF;
      else e = 4'($urandom);
      if ($urandom_range(0, 9) < 7) s = CODES[$urandom_range(0, 9)];
      else s = 7'($urandom);
      drive({e, 1'($urandom), s}, $urandom_range(1, 9));
    end
    drive(BLANK, 6);
    @(negedge clk);
    #1;
    check("frames_outstanding", fq.size(), 32'h0);
    check("code_errors_outstanding", cq.size(), 32'h0);
    check("enable_errors_outstanding", eq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_capture.md
# seg_capture

Passive monitor that sits on the stopwatch's multiplexed 7-segment bus: seg, decimal and the four digit enables. It decodes the scanned segment patterns back into four BCD digits plus decimal points. It publishes them as one coherent frame once every digit has been seen. It is the decode-side counterpart of the display path, used for on-chip lap capture and self-check of the display driver.

## Interface
- STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is accepted (legal range 2–255)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- seg  in  7  segment bus, active-low, seg[0]=a … seg[6]=g
- decimal  in  1  decimal point, active-low
- S0_enable  in  1  digit 0 (LSD) enable, active-low
- S1_enable  in  1  digit 1 enable, active-low
- S2_enable  in  1  digit 2 enable, active-low
- S3_enable  in  1  digit 3 (MSD) enable, active-low
- d0, d1, d2, d3  out  4 each  last complete frame, BCD; 4'hF marks an undecodable digit
- dp  out  4  last frame decimal points, active-high, dp[i] belongs to digit i
- frame_valid  out  1  one-cycle pulse when d0–d3 and dp update
- code_error  out  1  one-cycle pulse when an accepted digit had an illegal segment code
- enable_error  out  1  one-cycle pulse when a stable enable pattern has more than one enable low

## Operation
- Input stage: seg, decimal and the enable vector {S3..S0} are registered once. All decisions use the registered copies.
- Stability counter (8 bit):
  - Clears to 0 on any cycle where the registered sample differs from the previous registered sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Dwell acceptance: when the counter transitions to STABLE_CYCLES-1, the dwell is evaluated exactly once. The saturated count prevents re-acceptance within the same dwell.
- Enable pattern at acceptance:
  - 4'b1110 / 1101 / 1011 / 0111 selects digit 0 / 1 / 2 / 3: capture.
  - 4'b1111 (blank): ignore, no flags.
  - Any pattern with two or more bits low: no capture, pulse enable_error.
- Segment decode (active-low): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
- Any other seg value captures 4'hF and pulses code_error. This includes the driver's default "F" pattern 0001110.
- Capture writes the decoded digit and ~decimal into a shadow slot and sets that digit's bit in a 4-bit seen mask.
- A re-capture of an already-seen digit overwrites its shadow slot. The mask bit stays set.
- Frame commit: on the edge after the mask becomes 4'b1111:
  - copy all shadow slots to d0–d3/dp;
  - pulse frame_valid;
  - clear the mask to 0.
- A capture arriving on the commit edge goes into the shadow and sets its mask bit after the clear.
- Outputs change only on commit. They are never partially updated.

## Timing
- Reset values:
  - d0–d3 = 4'h0, dp = 4'b0000;
  - frame_valid = code_error = enable_error = 0;
  - mask = 0, counter = 0, input registers = all-ones (blank bus).
- Capture latency:
  - Edge E0 is the first edge that registers a new input pattern.
  - Shadow, mask and error pulses update on edge E0+STABLE_CYCLES-1.
  - A pattern must therefore be held for at least STABLE_CYCLES clocks to be accepted.
- Commit latency: d outputs, dp and frame_valid update one edge after the capture that completes the mask.
- A glitch shorter than STABLE_CYCLES clocks produces no capture and no error. It restarts the counter for the following pattern.
- Reset asserted mid-frame: discards shadow contents and mask, and returns outputs to reset values on the same edge. No frame_valid for the partial frame.
- Only one of code_error/enable_error can pulse per dwell. Either may coincide with frame_valid.

## Test plan
- Reset: hold reset 3 cycles with arbitrary bus activity → d0–d3=0, dp=0, all pulses 0. The first frame still needs all four digits after reset deasserts.
- Normal frame: scan digits 0..3 showing 4,3,2,1, 8 clocks each, dp on digit 2 only → one frame_valid one cycle after the digit-3 capture; d3..d0=1,2,3,4; dp=4'b0100.
- Glitch rejection: insert a 2-clock seg=0000000 (8) during the digit-1 dwell, then restore → the digit-1 value is unchanged and there is no extra capture; the frame result matches the scenario above.
- Illegal code: digit 2 driven with 0001110 for 8 clocks inside a full scan → code_error pulses once; d2=4'hF after commit.
- Bad enables: enable vector 4'b1100 held 8 clocks → enable_error pulses once, no mask change, no frame_valid. A subsequent full scan commits normally.
- Reset mid-frame: capture digits 0–2, pulse reset, then scan only digit 3 → no frame_valid. A full scan afterwards yields exactly one frame_valid.
